regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised register file for the pipelined datapath: two combinational read ports, one synchronous write port, and optional same-cycle write-to-read bypass. A per-register pending-write scoreboard tracks in-flight writes so hazard logic can stall. Sits in the decode stage: reads and issue come from decode, writes come from writeback.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
MAX_INFLIGHT, 3, maximum outstanding writes per register (>=1)
BYPASS, 1, 1 = read ports forward same-cycle write data
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending
Derived: AW = $clog2(NREGS), CW = $clog2(MAX_INFLIGHT+1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr_a  in  AW  read port A address
rd_addr_b  in  AW  read port B address
rd_data_a  out  XLEN  read port A data
rd_data_b  out  XLEN  read port B data
rd_pend_a  out  1  register at rd_addr_a has an outstanding write whose data is not available
rd_pend_b  out  1  same for port B
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
iss_valid  in  1  decode issues an instruction that will write iss_addr
iss_addr  in  AW  destination of the issuing instruction
iss_ready  out  1  issue is accepted this cycle
flush  in  1  synchronous clear of all pending counters (pipeline flush)
busy_any  out  1  any pending counter is non-zero
err_underflow  out  1  sticky: writeback arrived with no pending write

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0, all counters = 0, err_underflow = 0. Outputs during reset: rd_data_* = 0, rd_pend_* = 0, busy_any = 0, iss_ready = 1 unless flush = 1.
- Write: on the rising edge with wr_en = 1, regs[wr_addr] <= wr_data. Writes to address 0 are dropped when ZERO_REG = 1.
- Read: combinational, zero latency. With ZERO_REG = 1, address 0 returns 0.
- Bypass: with BYPASS = 1, wr_en = 1, wr_addr == rd_addr_x and the address is writable, rd_data_x = wr_data. With BYPASS = 0, the stored value is returned and new data becomes visible one cycle after the write.
- Counters: cnt[r] has width CW.
  - Issue accepted (iss_valid & iss_ready & writable iss_addr): cnt[iss_addr] +1.
  - Writeback (wr_en & writable wr_addr & cnt > 0): cnt[wr_addr] -1.
  - Issue and writeback to the same register in one cycle: net count unchanged.
  - Writeback when cnt = 0: the data write still occurs, the counter stays 0, and err_underflow is set at the next edge. It stays set until reset.
- iss_ready = !flush & (cnt[iss_addr] < MAX_INFLIGHT | (wr_en & wr_addr == iss_addr & cnt[iss_addr] > 0)). It is 1 for address 0 when ZERO_REG = 1.
- rd_pend_x = cnt[rd_addr_x] != 0, forced to 0 when BYPASS = 1 & wr_en & wr_addr == rd_addr_x & cnt == 1, because the last write is being forwarded. Always 0 for address 0 when ZERO_REG = 1.
- flush: at the edge, all counters are cleared. Register data is untouched, and the wr_en write still occurs. Issue is ignored that cycle. Decrements are irrelevant that cycle.
- busy_any is the OR-reduction of counter != 0, taken from registered state.
- No other state, and no multi-cycle latency.

Test Plan:
- Reset, then write 0xDEADBEEF to r5; read r5 on both ports the next cycle -> 0xDEADBEEF. Write r0 = 0x1234 -> r0 reads 0.
- BYPASS = 1: in the same cycle wr_en, wr_addr = 7, wr_data = 0xA5A5A5A5 and rd_addr_a = 7 -> rd_data_a = 0xA5A5A5A5 in that cycle. BYPASS = 0 -> old value, new value one cycle later.
- Issue r3 three times (MAX_INFLIGHT = 3) -> rd_pend = 1, iss_ready = 0 on the 4th attempt. A writeback to r3 in the same cycle as the 4th issue -> iss_ready = 1 and the count stays 3.
- Counter drain: with cnt[r9] = 1, wr_en to r9 with rd_addr_a = 9 -> rd_pend_a = 0 in that cycle with forwarded data. The next cycle cnt = 0 and busy_any = 0.
- Writeback to r4 with cnt = 0 -> the data is written and err_underflow = 1 from the next cycle. It holds until reset_n pulses low.
- Pend r1 and r2, assert flush with iss_valid to r6 -> all counters are 0 next cycle, r6 is not pending, busy_any = 0, and r1/r2 data is unchanged. Drop reset_n mid-sequence -> all state is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int MAX_INFLIGHT = 3,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1,
  localparam int AW          = $clog2(NREGS),
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  output logic            rd_pend_a,
  output logic            rd_pend_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic            flush,
  output logic            busy_any,
  output logic            err_underflow
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [CW-1:0]   cnt_q  [NREGS];
  logic [CW-1:0]   cnt_d  [NREGS];
  logic            err_q, err_d;

  logic            wr_ok_s, iss_ok_s, inc_s, dec_s;
  logic [CW-1:0]   wr_cnt_s, iss_cnt_s;
  logic [AW-1:0]   rd_addr_s [2];
  logic [XLEN-1:0] rd_data_s [2];
  logic            rd_pend_s [2];

  function automatic logic writable(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == {AW{1'b0}}));
  endfunction

  // Issue/writeback qualification and issue back-pressure.
  always_comb begin
    wr_ok_s   = wr_en & writable(wr_addr);
    iss_ok_s  = writable(iss_addr);
    wr_cnt_s  = cnt_q[wr_addr];
    iss_cnt_s = cnt_q[iss_addr];
    iss_ready = !flush & (!iss_ok_s | (iss_cnt_s < CNT_MAX) |
                          (wr_en & (wr_addr == iss_addr) & (iss_cnt_s != {CW{1'b0}})));
    inc_s     = iss_valid & iss_ready & iss_ok_s;
    dec_s     = wr_ok_s & (wr_cnt_s != {CW{1'b0}});
  end

  // Next-state for register data, pending counters and the sticky error.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_ok_s) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d[wr_addr] = regs_q[wr_addr];
    end
    if (flush) begin
      for (int i = 0; i < NREGS; i++) cnt_d[i] = {CW{1'b0}};
    end else if (inc_s && dec_s && (iss_addr == wr_addr)) begin
      cnt_d[iss_addr] = cnt_q[iss_addr];
    end else begin
      if (inc_s) begin
        cnt_d[iss_addr] = cnt_q[iss_addr] + CNT_ONE;
      end else begin
        cnt_d[iss_addr] = cnt_q[iss_addr];
      end
      if (dec_s) begin
        cnt_d[wr_addr] = cnt_q[wr_addr] - CNT_ONE;
      end else begin
        cnt_d[wr_addr] = cnt_d[wr_addr];
      end
    end
    err_d = err_q | (wr_ok_s & (wr_cnt_s == {CW{1'b0}}));
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
        cnt_q[i]  <= {CW{1'b0}};
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Read ports; forwarding is suppressed in reset so outputs read as zero.
  always_comb begin
    rd_addr_s[0] = rd_addr_a;
    rd_addr_s[1] = rd_addr_b;
    for (int p = 0; p < 2; p++) begin
      logic fwd;
      fwd = (BYPASS != 0) & reset_n & wr_ok_s & (wr_addr == rd_addr_s[p]);
      if (!writable(rd_addr_s[p])) begin
        rd_data_s[p] = {XLEN{1'b0}};
        rd_pend_s[p] = 1'b0;
      end else if (fwd) begin
        rd_data_s[p] = wr_data;
        rd_pend_s[p] = (cnt_q[rd_addr_s[p]] != {CW{1'b0}}) & (cnt_q[rd_addr_s[p]] != CNT_ONE);
      end else begin
        rd_data_s[p] = regs_q[rd_addr_s[p]];
        rd_pend_s[p] = (cnt_q[rd_addr_s[p]] != {CW{1'b0}});
      end
    end
    rd_data_a = rd_data_s[0];
    rd_data_b = rd_data_s[1];
    rd_pend_a = rd_pend_s[0];
    rd_pend_b = rd_pend_s[1];
  end

  // Status outputs from registered state.
  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < NREGS; i++) busy_any = busy_any | (cnt_q[i] != {CW{1'b0}});
    err_underflow = err_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a BYPASS=1 instance plus a BYPASS=0
// instance driven by the same stimulus.
module tb_regfile_scoreboard;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic        wr_en, iss_valid, flush;
  logic [31:0] rd_data_a, rd_data_b, rd_data_a0, rd_data_b0;
  logic        rd_pend_a, rd_pend_b, rd_pend_a0, rd_pend_b0;
  logic        iss_ready, busy_any, err_underflow;
  logic        iss_ready0, busy_any0, err_underflow0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  regfile_scoreboard #(.BYPASS(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush), .busy_any(busy_any),
    .err_underflow(err_underflow));

  regfile_scoreboard #(.BYPASS(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0), .rd_pend_a(rd_pend_a0), .rd_pend_b(rd_pend_b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .iss_ready(iss_ready0), .flush(flush), .busy_any(busy_any0),
    .err_underflow(err_underflow0));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    rd_addr_a = 5'd5; rd_addr_b = 5'd5; iss_valid = 1'b0; iss_addr = 5'd5; flush = 1'b0;
    #3;
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data_a: got %h want %h", rd_data_a, 32'h0); end
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pend_a: got %b want 0", rd_pend_a); end
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_any); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready: got %b want 1", iss_ready); end
    flush = 1'b1;
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iss_ready_flush: got %b want 0", iss_ready); end
    flush = 1'b0; wr_en = 1'b0;
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    iss_valid = 1'b1; iss_addr = 5'd5; rd_addr_a = 5'd5;
    tick();
    iss_valid = 1'b0;
    n_checks++; if (rd_pend_a !== 1'b1) begin n_fail++; $display("FAIL wr_pend_r5: got %b want 1", rd_pend_a); end
    n_checks++; if (busy_any !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy_any); end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #1;
    n_checks++; if (rd_data_a !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_a: got %h want %h", rd_data_a, 32'hDEAD_BEEF); end
    n_checks++; if (rd_data_b !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_b: got %h want %h", rd_data_b, 32'hDEAD_BEEF); end
    n_checks++; if (rd_data_a0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_a_nobyp: got %h want %h", rd_data_a0, 32'hDEAD_BEEF); end
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL wr_busy_clear: got %b want 0", busy_any); end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr_a = 5'd0;
    #1;
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h want %h", rd_data_a, 32'h0); end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h want %h", rd_data_a, 32'h0); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL r0_no_err: got %b want 0", err_underflow); end
  endtask

  task automatic test_bypass();
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    iss_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    n_checks++; if (rd_data_a !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_data: got %h want %h", rd_data_a, 32'hA5A5_A5A5); end
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL byp_pend: got %b want 0", rd_pend_a); end
    n_checks++; if (rd_data_a0 !== 32'h0) begin n_fail++; $display("FAIL nobyp_old: got %h want %h", rd_data_a0, 32'h0); end
    n_checks++; if (rd_pend_a0 !== 1'b1) begin n_fail++; $display("FAIL nobyp_pend: got %b want 1", rd_pend_a0); end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (rd_data_a0 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL nobyp_new: got %h want %h", rd_data_a0, 32'hA5A5_A5A5); end
    n_checks++; if (rd_pend_b !== 1'b0) begin n_fail++; $display("FAIL byp_pend_after: got %b want 0", rd_pend_b); end
  endtask

  task automatic test_max_inflight();
    rd_addr_a = 5'd3;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_addr = 5'd3;
      #1;
      n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready_%0d: got %b want 1", i, iss_ready); end
      tick();
    end
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_full: got %b want 0", iss_ready); end
    n_checks++; if (rd_pend_a !== 1'b1) begin n_fail++; $display("FAIL max_pend: got %b want 1", rd_pend_a); end
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready_wb: got %b want 1", iss_ready); end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_cnt_held: got %b want 0", iss_ready); end
    n_checks++; if (rd_data_a !== 32'h0000_0033) begin n_fail++; $display("FAIL max_data: got %h want %h", rd_data_a, 32'h33); end
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0030 + i;
      #1;
      n_checks++; if (rd_pend_a !== (i < 2)) begin n_fail++; $display("FAIL max_drain_pend_%0d: got %b want %b", i, rd_pend_a, (i < 2)); end
      tick();
    end
    wr_en = 1'b0;
    #1;
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL max_drained: got %b want 0", busy_any); end
  endtask

  task automatic test_drain();
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999; rd_addr_a = 5'd9;
    #1;
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL drain_pend: got %b want 0", rd_pend_a); end
    n_checks++; if (rd_data_a !== 32'h9999_9999) begin n_fail++; $display("FAIL drain_fwd: got %h want %h", rd_data_a, 32'h9999_9999); end
    n_checks++; if (busy_any !== 1'b1) begin n_fail++; $display("FAIL drain_busy_pre: got %b want 1", busy_any); end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL drain_pend_post: got %b want 0", rd_pend_a); end
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b want 0", busy_any); end
  endtask

  task automatic test_underflow();
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pre: got %b want 0", err_underflow); end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0044; rd_addr_a = 5'd4;
    #1;
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_same_cycle: got %b want 0", err_underflow); end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    n_checks++; if (rd_data_a !== 32'h0000_0044) begin n_fail++; $display("FAIL uf_data: got %h want %h", rd_data_a, 32'h44); end
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL uf_cnt_zero: got %b want 0", rd_pend_a); end
    tick(); tick();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
  endtask

  task automatic test_flush();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1111_1111;
    tick();
    wr_addr = 5'd2; wr_data = 32'h2222_2222;
    tick();
    wr_en = 1'b0; iss_valid = 1'b1; iss_addr = 5'd1;
    tick();
    iss_addr = 5'd2;
    tick();
    iss_valid = 1'b0; rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    #1;
    n_checks++; if ({rd_pend_a, rd_pend_b} !== 2'b11) begin n_fail++; $display("FAIL fl_pend_pre: got %b want 11", {rd_pend_a, rd_pend_b}); end
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL fl_iss_ready: got %b want 0", iss_ready); end
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    #1;
    n_checks++; if ({rd_pend_a, rd_pend_b} !== 2'b00) begin n_fail++; $display("FAIL fl_pend_post: got %b want 00", {rd_pend_a, rd_pend_b}); end
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL fl_busy: got %b want 0", busy_any); end
    n_checks++; if (rd_data_a !== 32'h1111_1111) begin n_fail++; $display("FAIL fl_r1: got %h want %h", rd_data_a, 32'h1111_1111); end
    n_checks++; if (rd_data_b !== 32'h2222_2222) begin n_fail++; $display("FAIL fl_r2: got %h want %h", rd_data_b, 32'h2222_2222); end
    rd_addr_a = 5'd6;
    #1;
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL fl_r6_pend: got %b want 0", rd_pend_a); end
  endtask

  task automatic test_async_reset();
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick();
    iss_valid = 1'b0; rd_addr_a = 5'd10; rd_addr_b = 5'd5;
    #1;
    n_checks++; if (busy_any !== 1'b1) begin n_fail++; $display("FAIL ar_busy_pre: got %b want 1", busy_any); end
    n_checks++; if (rd_data_b !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ar_r5_pre: got %h want %h", rd_data_b, 32'hDEAD_BEEF); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL ar_r5: got %h want %h", rd_data_b, 32'h0); end
    n_checks++; if (rd_pend_a !== 1'b0) begin n_fail++; $display("FAIL ar_pend: got %b want 0", rd_pend_a); end
    n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", busy_any); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", err_underflow); end
    #1 reset_n = 1'b1;
    tick();
    n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL ar_r5_post: got %h want %h", rd_data_b, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_max_inflight();
    test_drain();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
